// File: rtl/gobang_core.sv
// Gobang (N-in-a-row) game core.
// Holds the board, a wrapping cursor and the turn. After every legal move it
// walks the four line directions one cell per cycle to decide win or draw.
module gobang_core #(
   parameter  int BOARD_N = 15,
   parameter  int WIN_LEN = 5,
   localparam int COORD_W = (BOARD_N > 1) ? $clog2(BOARD_N) : 1
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               put,
   input  logic               right,
   input  logic               down,
   input  logic [COORD_W-1:0] rd_x,
   input  logic [COORD_W-1:0] rd_y,
   output logic [1:0]         rd_cell,
   output logic [COORD_W-1:0] cur_x,
   output logic [COORD_W-1:0] cur_y,
   output logic               turn,
   output logic               busy,
   output logic               move_done,
   output logic               illegal,
   output logic               game_over,
   output logic               winner,
   output logic               draw
);

   localparam int CELLS   = BOARD_N * BOARD_N;
   localparam int IDX_W   = $clog2(CELLS);
   localparam int CNT_W   = $clog2(WIN_LEN + 1);
   localparam int STONE_W = $clog2(CELLS + 1);
   // Probe coordinates carry a sign bit and one spare bit so a walk can
   // step one cell past either board edge before it is rejected.
   localparam int P_W     = COORD_W + 2;
   localparam logic signed [P_W-1:0] P_MAX = P_W'(BOARD_N - 1);
   localparam logic [COORD_W-1:0]    C_MAX = COORD_W'(BOARD_N - 1);

   typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

   state_t                state, state_nxt;
   logic [1:0]            board [CELLS];
   logic [COORD_W-1:0]    org_x, org_y;
   logic [STONE_W-1:0]    stones;
   logic [1:0]            dir;       // 0 horiz, 1 vert, 2 diag (+x,+y), 3 anti (+x,-y)
   logic                  side;      // 0 walking +delta, 1 walking -delta
   logic [CNT_W-1:0]      step;      // cells already examined on this side
   logic [CNT_W-1:0]      line_cnt;  // stones in line, origin included
   logic signed [P_W-1:0] px, py;    // cell examined this cycle

   logic [1:0]            code;
   logic [IDX_W-1:0]      cur_idx, rd_idx, probe_idx;
   logic                  cur_empty, probe_in, probe_hit;
   logic                  side_end, check_win, check_last, board_full;
   logic [CNT_W-1:0]      cnt_inc;
   logic signed [P_W-1:0] dx, dy, nx_dx, nx_dy, org_px, org_py;

   function automatic logic signed [P_W-1:0] delta_x(input logic [1:0] d);
      return (d == 2'd1) ? '0 : P_W'(1);
   endfunction

   function automatic logic signed [P_W-1:0] delta_y(input logic [1:0] d);
      case (d)
         2'd0:    return '0;
         2'd3:    return '1;
         default: return P_W'(1);
      endcase
   endfunction

   // Address decode for cursor, display port and walk probe; walk decisions.
   always_comb begin
      code       = turn ? 2'b10 : 2'b01;
      cur_idx    = IDX_W'(cur_y) * IDX_W'(BOARD_N) + IDX_W'(cur_x);
      cur_empty  = (board[cur_idx] == 2'b00);
      rd_idx     = IDX_W'(rd_y) * IDX_W'(BOARD_N) + IDX_W'(rd_x);
      rd_cell    = (rd_x <= C_MAX && rd_y <= C_MAX) ? board[rd_idx] : 2'b00;
      probe_in   = !px[P_W-1] && !py[P_W-1] && px <= P_MAX && py <= P_MAX;
      probe_idx  = IDX_W'(py[COORD_W-1:0]) * IDX_W'(BOARD_N) + IDX_W'(px[COORD_W-1:0]);
      probe_hit  = probe_in && (board[probe_idx] == code);
      cnt_inc    = line_cnt + 1'b1;
      check_win  = probe_hit && (cnt_inc == CNT_W'(WIN_LEN));
      // A side also stops once it has examined WIN_LEN-1 cells.
      side_end   = !probe_hit || (step == CNT_W'(WIN_LEN - 2));
      check_last = side_end && side && (dir == 2'd3) && !check_win;
      board_full = (stones == STONE_W'(CELLS));
      dx         = delta_x(dir);
      dy         = delta_y(dir);
      nx_dx      = delta_x(dir + 2'd1);
      nx_dy      = delta_y(dir + 2'd1);
      org_px     = P_W'(org_x);
      org_py     = P_W'(org_y);
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      // NOTE: clocked state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      // NOTE: default first, so no path through the case leaves state_nxt
      // unassigned and a latch is never inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (put && cur_empty) state_nxt = CHECK;
         CHECK:   if (check_win)        state_nxt = OVER;
                  else if (check_last)  state_nxt = board_full ? OVER : IDLE;
         OVER:    state_nxt = OVER;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state == CHECK);
   end

   // Board, cursor, turn, result flags and the line-walk datapath.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         // NOTE: the board is cleared on reset because a new game must start
         // empty; this is why it is a register array rather than a RAM.
         for (int i = 0; i < CELLS; i++) board[i] <= 2'b00;
         cur_x     <= '0;
         cur_y     <= '0;
         turn      <= 1'b0;
         move_done <= 1'b0;
         illegal   <= 1'b0;
         game_over <= 1'b0;
         winner    <= 1'b0;
         draw      <= 1'b0;
         stones    <= '0;
         org_x     <= '0;
         org_y     <= '0;
         dir       <= 2'd0;
         side      <= 1'b0;
         step      <= '0;
         line_cnt  <= '0;
         px        <= '0;
         py        <= '0;
      end else begin
         move_done <= 1'b0;
         illegal   <= 1'b0;
         case (state)
            IDLE: begin
               if (right) cur_x <= (cur_x == C_MAX) ? '0 : cur_x + 1'b1;
               if (down)  cur_y <= (cur_y == C_MAX) ? '0 : cur_y + 1'b1;
               if (put) begin
                  if (cur_empty) begin
                     board[cur_idx] <= code;
                     org_x          <= cur_x;
                     org_y          <= cur_y;
                     stones         <= stones + 1'b1;
                     dir            <= 2'd0;
                     side           <= 1'b0;
                     step           <= '0;
                     line_cnt       <= CNT_W'(1);
                     px             <= P_W'(cur_x) + P_W'(1);
                     py             <= P_W'(cur_y);
                  end else begin
                     illegal <= 1'b1;
                  end
               end
            end
            CHECK: begin
               if (check_win) begin
                  game_over <= 1'b1;
                  winner    <= turn;
                  draw      <= 1'b0;
                  move_done <= 1'b1;
               end else if (!side_end) begin
                  line_cnt <= cnt_inc;
                  step     <= step + 1'b1;
                  px       <= side ? px - dx : px + dx;
                  py       <= side ? py - dy : py + dy;
               end else if (!side) begin
                  // Positive side done: keep the count, walk the other way.
                  if (probe_hit) line_cnt <= cnt_inc;
                  side <= 1'b1;
                  step <= '0;
                  px   <= org_px - dx;
                  py   <= org_py - dy;
               end else if (dir != 2'd3) begin
                  dir      <= dir + 2'd1;
                  side     <= 1'b0;
                  step     <= '0;
                  line_cnt <= CNT_W'(1);
                  px       <= org_px + nx_dx;
                  py       <= org_py + nx_dy;
               end else begin
                  move_done <= 1'b1;
                  if (board_full) begin
                     game_over <= 1'b1;
                     draw      <= 1'b1;
                  end else begin
                     turn <= ~turn;
                  end
               end
            end
            default: ;  // OVER: board, cursor and flags hold
         endcase
      end
   end

endmodule

// File: tb/tb_gobang_core.sv
// Directed bench for gobang_core: a 15x15 instance for cursor, win, illegal
// and reset cases and a 5x5 instance for the full-board draw.
module tb_gobang_core;

   localparam int N  = 15;
   localparam int N5 = 5;
   localparam int CW  = 4;
   localparam int CW5 = 3;

   typedef struct {
      int   x;
      int   y;
      logic exp_turn;
      logic exp_over;
      logic exp_winner;
      logic exp_draw;
      int   exp_cyc;   // expected CHECK length, 0 = not compared
   } move_vec_t;

   logic clock = 1'b0;
   logic resetn;
   logic put, right, down;
   logic [CW-1:0] rd_x, rd_y;
   bit   use5;

   int checks = 0;
   int errors = 0;
   int mx [2];
   int my [2];

   // 15x15 instance
   logic          put_a, right_a, down_a;
   logic [1:0]    rd_cell_a;
   logic [CW-1:0] cur_x_a, cur_y_a;
   logic          turn_a, busy_a, move_done_a, illegal_a, game_over_a, winner_a, draw_a;
   // 5x5 instance
   logic          put_b, right_b, down_b;
   logic [1:0]    rd_cell_b;
   logic [CW5-1:0] cur_x_b, cur_y_b;
   logic          turn_b, busy_b, move_done_b, illegal_b, game_over_b, winner_b, draw_b;
   // outputs of the selected instance
   logic [1:0]    s_rd_cell;
   logic [CW-1:0] s_cur_x, s_cur_y;
   logic          s_turn, s_busy, s_move_done, s_illegal, s_game_over, s_winner, s_draw;

   assign put_a   = put   & ~use5;
   assign right_a = right & ~use5;
   assign down_a  = down  & ~use5;
   assign put_b   = put   & use5;
   assign right_b = right & use5;
   assign down_b  = down  & use5;

   gobang_core dut (
      .clock(clock), .resetn(resetn), .put(put_a), .right(right_a), .down(down_a),
      .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell_a), .cur_x(cur_x_a), .cur_y(cur_y_a),
      .turn(turn_a), .busy(busy_a), .move_done(move_done_a), .illegal(illegal_a),
      .game_over(game_over_a), .winner(winner_a), .draw(draw_a)
   );

   gobang_core #(.BOARD_N(5), .WIN_LEN(5)) dut5 (
      .clock(clock), .resetn(resetn), .put(put_b), .right(right_b), .down(down_b),
      .rd_x(rd_x[CW5-1:0]), .rd_y(rd_y[CW5-1:0]), .rd_cell(rd_cell_b),
      .cur_x(cur_x_b), .cur_y(cur_y_b), .turn(turn_b), .busy(busy_b),
      .move_done(move_done_b), .illegal(illegal_b), .game_over(game_over_b),
      .winner(winner_b), .draw(draw_b)
   );

   always_comb begin
      if (use5) begin
         s_rd_cell = rd_cell_b;   s_cur_x = {1'b0, cur_x_b}; s_cur_y = {1'b0, cur_y_b};
         s_turn = turn_b;         s_busy = busy_b;           s_move_done = move_done_b;
         s_illegal = illegal_b;   s_game_over = game_over_b; s_winner = winner_b;
         s_draw = draw_b;
      end else begin
         s_rd_cell = rd_cell_a;   s_cur_x = cur_x_a;         s_cur_y = cur_y_a;
         s_turn = turn_a;         s_busy = busy_a;           s_move_done = move_done_a;
         s_illegal = illegal_a;   s_game_over = game_over_a; s_winner = winner_a;
         s_draw = draw_a;
      end
   end

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0; put = 1'b0; right = 1'b0; down = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      mx = '{0, 0};
      my = '{0, 0};
   endtask

   // Walk the cursor of the selected instance to (x,y) using the bench's own
   // record of where the cursor is.
   task automatic move_to(input int x, input int y);
      int n, nr, nd;
      n  = use5 ? N5 : N;
      nr = (x - mx[use5] + n) % n;
      nd = (y - my[use5] + n) % n;
      for (int k = 0; k < nr || k < nd; k++) begin
         right = (k < nr);
         down  = (k < nd);
         tick();
      end
      right = 1'b0;
      down  = 1'b0;
      mx[use5] = x;
      my[use5] = y;
   endtask

   // Place a stone and wait (bounded) for move_done; returns CHECK length.
   task automatic place(input int x, input int y, output int ncyc);
      int guard;
      move_to(x, y);
      put = 1'b1;
      tick();
      put = 1'b0;
      ncyc  = 0;
      guard = 0;
      while (!s_move_done && guard < 300) begin
         if (s_busy) ncyc++;
         guard++;
         tick();
      end
      check($sformatf("move_done(%0d,%0d)", x, y), s_move_done, 1'b1);
   endtask

   task automatic run_vec(input move_vec_t v, input string tag, input int idx);
      int cyc;
      place(v.x, v.y, cyc);
      check($sformatf("%s%0d_turn", tag, idx), s_turn, v.exp_turn);
      check($sformatf("%s%0d_game_over", tag, idx), s_game_over, v.exp_over);
      check($sformatf("%s%0d_winner", tag, idx), s_winner, v.exp_winner);
      check($sformatf("%s%0d_draw", tag, idx), s_draw, v.exp_draw);
      if (v.exp_cyc != 0) check($sformatf("%s%0d_check_cycles", tag, idx), cyc, v.exp_cyc);
   endtask

   move_vec_t hvec [9];
   move_vec_t avec [10];
   move_vec_t dvec [25];
   int pat [5][5] = '{'{0, 0, 1, 1, 0},
                      '{1, 1, 0, 0, 1},
                      '{0, 0, 1, 1, 0},
                      '{1, 1, 0, 0, 1},
                      '{0, 1, 1, 0, 0}};

   initial begin
      int p0x [13], p0y [13], p1x [12], p1y [12];
      int p0n, p1n, cyc, seen, bad;

      // Horizontal win for player0 on row 7; player1 fills row 8.
      hvec[0] = '{0, 7, 1'b1, 1'b0, 1'b0, 1'b0, 8};
      hvec[1] = '{0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8};
      hvec[2] = '{1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 9};
      hvec[3] = '{1, 8, 1'b0, 1'b0, 1'b0, 1'b0, 9};
      hvec[4] = '{2, 7, 1'b1, 1'b0, 1'b0, 1'b0, 10};
      hvec[5] = '{2, 8, 1'b0, 1'b0, 1'b0, 1'b0, 10};
      hvec[6] = '{3, 7, 1'b1, 1'b0, 1'b0, 1'b0, 11};
      hvec[7] = '{3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 11};
      hvec[8] = '{4, 7, 1'b0, 1'b1, 1'b0, 1'b0, 5};
      // Anti-diagonal win for player1 ending in the top-right corner.
      avec[0] = '{0, 14, 1'b1, 1'b0, 1'b0, 1'b0, 8};
      avec[1] = '{10, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      avec[2] = '{2, 14, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      avec[3] = '{11, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      avec[4] = '{4, 14, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      avec[5] = '{12, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      avec[6] = '{6, 14, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      avec[7] = '{13, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      avec[8] = '{8, 14, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      avec[9] = '{14, 0, 1'b1, 1'b1, 1'b1, 1'b0, 11};
      // 5x5 draw: alternate player0 / player1 cells of a pattern with no full line.
      p0n = 0;
      p1n = 0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            if (pat[y][x] == 0) begin p0x[p0n] = x; p0y[p0n] = y; p0n++; end
            else                begin p1x[p1n] = x; p1y[p1n] = y; p1n++; end
      for (int i = 0; i < 25; i++) begin
         dvec[i].x          = (i % 2 == 0) ? p0x[i/2] : p1x[i/2];
         dvec[i].y          = (i % 2 == 0) ? p0y[i/2] : p1y[i/2];
         dvec[i].exp_turn   = (i == 24) ? 1'b0 : 1'((i + 1) % 2);
         dvec[i].exp_over   = (i == 24);
         dvec[i].exp_winner = 1'b0;
         dvec[i].exp_draw   = (i == 24);
         dvec[i].exp_cyc    = 0;
      end

      use5 = 1'b0;
      rd_x = 4'd7;
      rd_y = 4'd7;
      do_reset();

      // Reset state.
      check("rst_cur_x", s_cur_x, 0);
      check("rst_cur_y", s_cur_y, 0);
      check("rst_turn", s_turn, 0);
      check("rst_busy", s_busy, 0);
      check("rst_move_done", s_move_done, 0);
      check("rst_illegal", s_illegal, 0);
      check("rst_game_over", s_game_over, 0);
      check("rst_winner", s_winner, 0);
      check("rst_draw", s_draw, 0);
      check("rst_cell", s_rd_cell, 0);

      // Cursor wrap.
      move_to(14, 0);
      check("wrap_start", s_cur_x, 14);
      for (int i = 0; i < 15; i++) begin right = 1'b1; tick(); end
      right = 1'b0;
      check("wrap_15_rights", s_cur_x, 14);
      right = 1'b1; tick(); right = 1'b0;
      check("wrap_to_zero", s_cur_x, 0);
      right = 1'b1; down = 1'b1; tick(); right = 1'b0; down = 1'b0;
      check("both_x", s_cur_x, 1);
      check("both_y", s_cur_y, 1);
      mx[0] = 1;
      my[0] = 1;

      // Horizontal win.
      do_reset();
      for (int i = 0; i < 9; i++) run_vec(hvec[i], "h", i);
      put = 1'b1; right = 1'b1; tick(); put = 1'b0; right = 1'b0;
      check("over_busy", s_busy, 0);
      check("over_cur_frozen", s_cur_x, 4);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (s_busy || s_move_done) seen++;
         tick();
      end
      check("over_no_activity", seen, 0);
      check("over_game_over", s_game_over, 1);
      rd_x = 4'd15; rd_y = 4'd7; #1;
      check("rd_out_of_range", s_rd_cell, 2'b00);
      rd_x = 4'd0;  rd_y = 4'd8; #1;
      check("rd_player1_cell", s_rd_cell, 2'b10);

      // Occupied put.
      do_reset();
      place(3, 3, cyc);
      check("ill_turn_before", s_turn, 1);
      put = 1'b1; tick(); put = 1'b0;
      check("ill_pulse", s_illegal, 1);
      check("ill_no_busy", s_busy, 0);
      check("ill_turn_kept", s_turn, 1);
      tick();
      check("ill_single", s_illegal, 0);
      rd_x = 4'd3; rd_y = 4'd3; #1;
      check("ill_cell_kept", s_rd_cell, 2'b01);

      // Anti-diagonal corner win.
      do_reset();
      for (int i = 0; i < 10; i++) run_vec(avec[i], "a", i);

      // Reset in the middle of CHECK, with strobes held during reset.
      do_reset();
      move_to(5, 5);
      put = 1'b1; tick(); put = 1'b0;
      check("mid_busy", s_busy, 1);
      resetn = 1'b0; put = 1'b1; right = 1'b1; down = 1'b1;
      tick();
      check("mid_rst_cur_x", s_cur_x, 0);
      check("mid_rst_cur_y", s_cur_y, 0);
      check("mid_rst_turn", s_turn, 0);
      check("mid_rst_busy", s_busy, 0);
      check("mid_rst_move_done", s_move_done, 0);
      check("mid_rst_illegal", s_illegal, 0);
      check("mid_rst_flags", {s_game_over, s_winner, s_draw}, 3'b000);
      bad = 0;
      for (int y = 0; y < N; y++)
         for (int x = 0; x < N; x++) begin
            rd_x = CW'(x); rd_y = CW'(y); #1;
            if (s_rd_cell != 2'b00) bad++;
         end
      check("mid_rst_cells_clear", bad, 0);
      resetn = 1'b1; put = 1'b0; right = 1'b0; down = 1'b0;
      mx = '{0, 0};
      my = '{0, 0};
      tick();
      check("mid_after_busy", s_busy, 0);
      check("mid_after_cur", {s_cur_x, s_cur_y}, 0);

      // 5x5 draw.
      use5 = 1'b1;
      do_reset();
      for (int i = 0; i < 25; i++) run_vec(dvec[i], "d", i);
      rd_x = 4'd4; rd_y = 4'd4; #1;
      check("d_cell_4_4", s_rd_cell, 2'b01);
      rd_x = 4'd5; rd_y = 4'd0; #1;
      check("d_rd_out_of_range", s_rd_cell, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
